// File: rtl/sram_controller.sv
// Sequencer between the data cache and a 16-bit asynchronous SRAM: one 32-bit word
// write (2 halfword slots) or one 64-bit line read (4 slots) with programmable wait states.
module sram_controller #(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdEnIn,
    input  logic        wrEnIn,
    input  logic [31:0] adrIn,
    input  logic [31:0] wDataIn,
    output logic [63:0] readDataOut,
    output logic        readyOut,
    output logic [17:0] sramAddrOut,
    inout  wire  [15:0] sramDqIo,
    output logic        sramWeNOut,
    output logic        sramOeNOut,
    output logic        sramCeNOut,
    output logic        sramUbNOut,
    output logic        sramLbNOut
);

    localparam int             CW       = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0]  CYC_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t         state_reg;
    logic           is_write_reg;
    logic [15:0]    wdata_hi_reg;
    logic [CW-1:0]  cyc_reg;
    logic [1:0]     slot_reg;
    logic [17:0]    addr_reg;
    logic           we_n_reg;
    logic           oe_n_reg;
    logic           ce_n_reg;
    logic           dq_oe_reg;
    logic [15:0]    dq_out_reg;
    logic [15:0]    lane_reg [4];

    logic [31:0]    off;
    logic           slot_end;
    logic           last_slot;
    logic           sample_en;
    logic           unused_off;

    // Offset wraps modulo 2^32; only the halfword bits reach the SRAM.
    assign off        = adrIn - BASE_ADDR;
    assign unused_off = ^{off[31:19], off[1:0]};
    assign slot_end   = (cyc_reg == CYC_LAST);
    assign last_slot  = is_write_reg ? (slot_reg == 2'd1) : (slot_reg == 2'd3);
    assign sample_en  = (state_reg == ACCESS) && !is_write_reg && slot_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            is_write_reg <= 1'b0;
            wdata_hi_reg <= '0;
            cyc_reg      <= '0;
            slot_reg     <= '0;
            addr_reg     <= '0;
            we_n_reg     <= 1'b1;
            oe_n_reg     <= 1'b1;
            ce_n_reg     <= 1'b1;
            dq_oe_reg    <= 1'b0;
            dq_out_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (wrEnIn || rdEnIn) begin
                        state_reg    <= ACCESS;
                        is_write_reg <= wrEnIn;
                        wdata_hi_reg <= wDataIn[31:16];
                        cyc_reg      <= '0;
                        slot_reg     <= '0;
                        ce_n_reg     <= 1'b0;
                        addr_reg     <= wrEnIn ? {off[18:2], 1'b0} : {off[18:3], 2'b00};
                        we_n_reg     <= ~wrEnIn;
                        oe_n_reg     <= wrEnIn;
                        dq_oe_reg    <= wrEnIn;
                        dq_out_reg   <= wDataIn[15:0];
                    end
                end
                ACCESS: begin
                    if (slot_end) begin
                        cyc_reg <= '0;
                        if (last_slot) begin
                            state_reg <= DONE;
                            slot_reg  <= '0;
                            ce_n_reg  <= 1'b1;
                            we_n_reg  <= 1'b1;
                            oe_n_reg  <= 1'b1;
                            dq_oe_reg <= 1'b0;
                        end else begin
                            slot_reg   <= slot_reg + 2'd1;
                            addr_reg   <= addr_reg + 18'd1;
                            we_n_reg   <= ~is_write_reg;
                            dq_out_reg <= wdata_hi_reg;
                        end
                    end else begin
                        cyc_reg  <= cyc_reg + CW'(1);
                        // WE_N rises for the final cycle of a slot so that edge commits the halfword.
                        we_n_reg <= ~(is_write_reg && ((cyc_reg + CW'(1)) != CYC_LAST));
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    lane_reg[gi] <= '0;
                end else if (sample_en && (slot_reg == 2'(gi))) begin
                    lane_reg[gi] <= sramDqIo;
                end
            end
        end
    endgenerate

    assign readDataOut = {lane_reg[3], lane_reg[2], lane_reg[1], lane_reg[0]};
    assign readyOut    = (state_reg == DONE) ||
                         ((state_reg == IDLE) && !rdEnIn && !wrEnIn);
    assign sramAddrOut = addr_reg;
    assign sramWeNOut  = we_n_reg;
    assign sramOeNOut  = oe_n_reg;
    assign sramCeNOut  = ce_n_reg;
    assign sramUbNOut  = ce_n_reg;
    assign sramLbNOut  = ce_n_reg;
    assign sramDqIo    = dq_oe_reg ? dq_out_reg : 16'bz;

endmodule
